// File: rtl/serial_loader_if.sv
// RAM write bus and status outputs of the serial program loader.
// master: driven by serial_loader. slave: RAM / CPU reset side.
interface serial_loader_if;
  logic [11:0] ram_address;
  logic [7:0]  ram_data;
  logic        ram_we_bar;
  logic        busy;
  logic        done;
  logic        error;
  logic        cpu_rst_bar;

  modport master (output ram_address, ram_data, ram_we_bar, busy, done, error, cpu_rst_bar);
  modport slave  (input  ram_address, ram_data, ram_we_bar, busy, done, error, cpu_rst_bar);
endinterface

// File: rtl/serial_loader.sv
// serial_loader: receives a framed program image on an 8N1 serial line and writes it
// into the 4K program RAM from address 0, holding the CPU in reset until done.
// Frame: SYNC_BYTE, LEN_HI, LEN_LO, LEN data bytes [, CSUM].
// Build option: SERIAL_LOADER_CHECKSUM_EN adds the trailing 8-bit sum byte and its check.
module serial_loader #(
  parameter int         CLKS_PER_BIT = 16,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic             clk,
  input  logic             rst_bar,
  input  logic             rx,
  serial_loader_if.master  bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  // ---------------- RX front end ----------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_st_t;

  logic          rx_meta, rx_s;
  rx_st_t        rx_st, rx_nxt;
  logic [CW-1:0] clk_cnt, cnt_nxt;
  logic [2:0]    bit_idx, idx_nxt;
  logic [7:0]    shreg, sh_nxt;
  logic          byte_valid, frame_err;

  // two-flop synchronizer, preset to idle-high so reset never looks like a start bit
  always_ff @(posedge clk or negedge rst_bar) begin
    if (!rst_bar) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // receiver state register
  always_ff @(posedge clk or negedge rst_bar) begin
    if (!rst_bar) begin
      rx_st   <= RX_IDLE;
      clk_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      rx_st   <= rx_nxt;
      clk_cnt <= cnt_nxt;
      bit_idx <= idx_nxt;
      shreg   <= sh_nxt;
    end
  end

  // receiver next state: start recheck at half bit, then sample at each bit centre
  always_comb begin
    rx_nxt     = rx_st;
    cnt_nxt    = clk_cnt + CW'(1);
    idx_nxt    = bit_idx;
    sh_nxt     = shreg;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    unique case (rx_st)
      RX_IDLE: begin
        cnt_nxt = '0;
        idx_nxt = '0;
        if (!rx_s) rx_nxt = RX_START;
      end
      RX_START: begin
        if (clk_cnt == HALF) begin
          cnt_nxt = '0;
          rx_nxt  = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (clk_cnt == FULL) begin
          cnt_nxt = '0;
          sh_nxt  = {rx_s, shreg[7:1]};
          idx_nxt = bit_idx + 3'd1;
          if (bit_idx == 3'd7) rx_nxt = RX_STOP;
        end
      end
      RX_STOP: begin
        if (clk_cnt == FULL) begin
          cnt_nxt    = '0;
          rx_nxt     = RX_IDLE;
          byte_valid = rx_s;
          frame_err  = !rx_s;
        end
      end
      default: rx_nxt = RX_IDLE;
    endcase
  end

  // ---------------- frame FSM ----------------
  typedef enum logic [2:0] {
    S_SYNC, S_LENH, S_LENL, S_DATA,
`ifdef SERIAL_LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE, S_ERR
  } st_t;

  // state following the last data byte (or an empty image)
`ifdef SERIAL_LOADER_CHECKSUM_EN
  localparam st_t ST_END = S_CSUM;
`else
  localparam st_t ST_END = S_DONE;
`endif

  st_t        st, st_nxt;
  logic [3:0] len_hi;
  logic [11:0] len, count, count_inc;
  logic       sync_hit, lenh_ld, lenl_ld, wr;
`ifdef SERIAL_LOADER_CHECKSUM_EN
  logic [7:0] sum;
`endif

  assign count_inc = count + 12'd1;
  assign bus.busy  = !(st inside {S_SYNC, S_DONE, S_ERR});

  // frame state register
  always_ff @(posedge clk or negedge rst_bar) begin
    if (!rst_bar) st <= S_SYNC;
    else          st <= st_nxt;
  end

  // frame next state and datapath controls
  always_comb begin
    st_nxt   = st;
    sync_hit = 1'b0;
    lenh_ld  = 1'b0;
    lenl_ld  = 1'b0;
    wr       = 1'b0;
    unique case (st)
      S_SYNC, S_ERR: begin
        // a framing error here just drops the byte
        if (byte_valid && shreg == SYNC_BYTE) begin
          st_nxt   = S_LENH;
          sync_hit = 1'b1;
        end
      end
      S_LENH: begin
        if (frame_err) st_nxt = S_ERR;
        else if (byte_valid) begin
          if (shreg[7:4] != 4'd0) st_nxt = S_ERR;
          else begin
            st_nxt  = S_LENL;
            lenh_ld = 1'b1;
          end
        end
      end
      S_LENL: begin
        if (frame_err) st_nxt = S_ERR;
        else if (byte_valid) begin
          lenl_ld = 1'b1;
          st_nxt  = ({len_hi, shreg} == 12'd0) ? ST_END : S_DATA;
        end
      end
      S_DATA: begin
        if (frame_err) st_nxt = S_ERR;
        else if (byte_valid) begin
          wr = 1'b1;
          if (count_inc == len) st_nxt = ST_END;
        end
      end
`ifdef SERIAL_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (frame_err) st_nxt = S_ERR;
        else if (byte_valid) st_nxt = (shreg == sum) ? S_DONE : S_ERR;
      end
`endif
      S_DONE: st_nxt = S_DONE;
      default: st_nxt = S_SYNC;
    endcase
  end

  // length, counter, RAM write port and sticky status
  always_ff @(posedge clk or negedge rst_bar) begin
    if (!rst_bar) begin
      len_hi          <= '0;
      len             <= '0;
      count           <= '0;
      bus.ram_address <= '0;
      bus.ram_data    <= '0;
      bus.ram_we_bar  <= 1'b1;
      bus.done        <= 1'b0;
      bus.error       <= 1'b0;
      bus.cpu_rst_bar <= 1'b0;
    end else begin
      // strobe lives exactly one clk; byte_valid pulses are a bit time apart
      bus.ram_we_bar <= !wr;
      if (lenh_ld) len_hi <= shreg[3:0];
      if (lenl_ld) len    <= {len_hi, shreg};
      if (sync_hit) count <= '0;
      else if (wr) begin
        bus.ram_address <= count;
        bus.ram_data    <= shreg;
        count           <= count_inc;
      end
      if (st == S_DONE) begin
        bus.done        <= 1'b1;
        bus.cpu_rst_bar <= 1'b1;
      end
      // a fresh sync byte out of ERR wins over the sticky set
      if (sync_hit)       bus.error <= 1'b0;
      else if (st == S_ERR) bus.error <= 1'b1;
    end
  end

`ifdef SERIAL_LOADER_CHECKSUM_EN
  // running modulo-256 sum of the data bytes
  always_ff @(posedge clk or negedge rst_bar) begin
    if (!rst_bar)      sum <= '0;
    else if (sync_hit) sum <= '0;
    else if (wr)       sum <= sum + shreg;
  end
`endif

endmodule

// File: tb/tb_serial_loader.sv
// Directed bench for serial_loader (CLKS_PER_BIT=16). Follows the build's
// SERIAL_LOADER_CHECKSUM_EN setting when forming frames.
module tb_serial_loader;
  localparam int BIT = 16;

  logic clk = 1'b0;
  logic rst_bar = 1'b0;
  logic rx = 1'b1;
  always #5 clk = ~clk;

  serial_loader_if bus();

  serial_loader #(.CLKS_PER_BIT(BIT), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst_bar(rst_bar), .rx(rx), .bus(bus)
  );

  // RAM model and strobe monitor, sampled on the falling edge
  logic [7:0] mem [0:4095];
  int wr_total = 0, dbl_total = 0, cyc = 0, last_wr_cyc = 0, done_cyc = 0;
  logic prev_low = 1'b0, prev_done = 1'b0;
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (bus.ram_we_bar === 1'b0) begin
      mem[bus.ram_address] = bus.ram_data;
      wr_total    = wr_total + 1;
      last_wr_cyc = cyc;
      if (prev_low) dbl_total = dbl_total + 1;
      prev_low = 1'b1;
    end else prev_low = 1'b0;
    if (bus.done === 1'b1 && !prev_done) done_cyc = cyc;
    prev_done = bus.done;
  end

  int n_chk = 0, n_fail = 0;
  int base, dbl_base;
  logic [7:0] fq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
    rx = 1'b1;
  endtask

  task automatic send_q();
    foreach (fq[i]) send_byte(fq[i], 1'b1);
    idle(6);
  endtask

  task automatic do_reset();
    rst_bar = 1'b0;
    rx = 1'b1;
    idle(3);
    rst_bar = 1'b1;
    idle(3);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_addr"}, 32'(bus.ram_address), 0);
    chk({tag, "_data"}, 32'(bus.ram_data), 0);
    chk({tag, "_we"},   32'(bus.ram_we_bar), 1);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
    chk({tag, "_err"},  32'(bus.error), 0);
    chk({tag, "_cpu"},  32'(bus.cpu_rst_bar), 0);
  endtask

  task automatic t1_frame();
    fq = '{8'hA5, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33};
`ifdef SERIAL_LOADER_CHECKSUM_EN
    fq.push_back(8'h66);
`endif
    send_q();
  endtask

  task automatic chk_t1(input string tag);
    chk({tag, "_nwr"}, 32'(wr_total - base), 3);
    chk({tag, "_m0"}, 32'(mem[0]), 32'h11);
    chk({tag, "_m1"}, 32'(mem[1]), 32'h22);
    chk({tag, "_m2"}, 32'(mem[2]), 32'h33);
    chk({tag, "_dbl"}, 32'(dbl_total - dbl_base), 0);
    chk({tag, "_done"}, 32'(bus.done), 1);
    chk({tag, "_cpu"}, 32'(bus.cpu_rst_bar), 1);
    chk({tag, "_err"}, 32'(bus.error), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
  endtask

  initial begin
    // reset state
    idle(3);
    chk_reset_vals("rst");
    rst_bar = 1'b1;
    idle(3);

    // 1: basic three-byte image
    base = wr_total; dbl_base = dbl_total;
    t1_frame();
    chk_t1("t1");
    // rx ignored once done
    base = wr_total;
    fq = '{8'hA5, 8'h00, 8'h01, 8'h77};
    send_q();
    chk("t1_ignore_nwr", 32'(wr_total - base), 0);
    chk("t1_ignore_busy", 32'(bus.busy), 0);

`ifdef SERIAL_LOADER_CHECKSUM_EN
    // 2: bad checksum then good retry
    do_reset();
    fq = '{8'hA5, 8'h00, 8'h02, 8'hAA, 8'hBB, 8'h00};
    send_q();
    chk("t2_err", 32'(bus.error), 1);
    chk("t2_cpu", 32'(bus.cpu_rst_bar), 0);
    chk("t2_done", 32'(bus.done), 0);
    base = wr_total;
    fq = '{8'hA5, 8'h00, 8'h02, 8'hAA, 8'hBB, 8'h65};
    send_q();
    chk("t2r_err", 32'(bus.error), 0);
    chk("t2r_done", 32'(bus.done), 1);
    chk("t2r_nwr", 32'(wr_total - base), 2);
    chk("t2r_m0", 32'(mem[0]), 32'hAA);
    chk("t2r_m1", 32'(mem[1]), 32'hBB);
`endif

    // 3: junk and a short glitch before a good frame
    do_reset();
    base = wr_total; dbl_base = dbl_total;
    fq = '{8'h00, 8'hFF, 8'h5A};
    send_q();
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(40);
    chk("t3_junk_nwr", 32'(wr_total - base), 0);
    chk("t3_junk_busy", 32'(bus.busy), 0);
    chk("t3_junk_err", 32'(bus.error), 0);
    t1_frame();
    chk_t1("t3");

    // 4: framing error on second data byte
    do_reset();
    base = wr_total;
    fq = '{8'hA5, 8'h00, 8'h03, 8'h11};
    send_q();
    send_byte(8'h22, 1'b0);
    send_bit(1'b1);
    idle(6);
    chk("t4_err", 32'(bus.error), 1);
    chk("t4_nwr", 32'(wr_total - base), 1);
    chk("t4_m0", 32'(mem[0]), 32'h11);
    chk("t4_done", 32'(bus.done), 0);
    chk("t4_cpu", 32'(bus.cpu_rst_bar), 0);
    chk("t4_busy", 32'(bus.busy), 0);

    // 5: reset in the middle of the second data byte
    do_reset();
    base = wr_total;
    fq = '{8'hA5, 8'h00, 8'h03, 8'h11};
    send_q();
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    chk("t5_busy_mid", 32'(bus.busy), 1);
    chk("t5_nwr_mid", 32'(wr_total - base), 1);
    rst_bar = 1'b0;
    idle(2);
    chk_reset_vals("t5rst");
    rx = 1'b1;
    idle(2);
    rst_bar = 1'b1;
    idle(20);
    base = wr_total; dbl_base = dbl_total;
    t1_frame();
    chk_t1("t5");

    // 6: length upper nibble set, then recovery by a new sync byte
    do_reset();
    fq = '{8'hA5, 8'h10, 8'h00};
    send_q();
    chk("t6_lenhi_err", 32'(bus.error), 1);
    chk("t6_lenhi_busy", 32'(bus.busy), 0);
    base = wr_total;
    fq = '{8'hA5, 8'h00, 8'h01, 8'h5C};
`ifdef SERIAL_LOADER_CHECKSUM_EN
    fq.push_back(8'h5C);
`endif
    send_q();
    chk("t6_retry_err", 32'(bus.error), 0);
    chk("t6_retry_done", 32'(bus.done), 1);
    chk("t6_retry_m0", 32'(mem[0]), 32'h5C);
    chk("t6_retry_nwr", 32'(wr_total - base), 1);

`ifndef SERIAL_LOADER_CHECKSUM_EN
    // 6: no checksum byte, done follows the last write by one clk
    do_reset();
    base = wr_total;
    fq = '{8'hA5, 8'h00, 8'h02, 8'hAA, 8'hBB};
    send_q();
    chk("t6nc_done", 32'(bus.done), 1);
    chk("t6nc_nwr", 32'(wr_total - base), 2);
    chk("t6nc_m1", 32'(mem[1]), 32'hBB);
    chk("t6nc_lat", 32'(done_cyc - last_wr_cyc), 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
